// File: rtl/alu_sched_pkg.sv
// Shared constants, FSM state type and error rule for the ALU request scheduler.
package alu_sched_pkg;

    localparam logic [3:0] OP_ADD      = 4'd0;
    localparam logic [3:0] OP_SUB      = 4'd1;
    localparam logic [3:0] OP_MUL      = 4'd2;
    localparam logic [3:0] OP_DIV      = 4'd3;
    localparam logic [7:0] ALU_ERR_VAL = 8'hAC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    // An operation is flagged when the opcode is undefined or it divides by zero.
    function automatic logic is_err(input logic [3:0] op, input logic [7:0] b);
        return (op > OP_DIV) || ((op == OP_DIV) && (b == 8'd0));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the requester at ptr has highest priority,
// then ptr+1, ... wrapping at N_REQ-1.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one external ALU between N_REQ requesters: round-robin accept, fixed-latency
// execute, then hold the captured result until the owning requester takes it.
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    input  logic [4*N_REQ-1:0]   req_op,
    output logic [N_REQ-1:0]     resp_valid,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic [7:0]           resp_result,
    output logic                 resp_carry,
    output logic                 resp_err,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_op_code,
    input  logic [7:0]           alu_result,
    input  logic                 alu_carry_out,
    output logic                 busy,
    output logic [15:0]          op_count,
    output logic [15:0]          err_count
);

    localparam int unsigned IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [2:0]  LAT_INIT = 3'(ALU_LAT - 1);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [2:0]       lat_cnt_q, lat_cnt_d;
    logic [7:0]       res_q, res_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic [15:0]      op_count_q, op_count_d;
    logic [15:0]      err_count_q, err_count_d;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   gnt_id;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        gnt_id = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gnt_id = IDW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        lat_cnt_d   = lat_cnt_q;
        res_d       = res_q;
        carry_d     = carry_q;
        err_d       = err_q;
        op_count_d  = op_count_q;
        err_count_d = err_count_q;
        req_ready   = '0;

        unique case (state_q)
            S_IDLE: begin
                // The grant itself is the ready, so any granted requester is accepted now.
                req_ready = grant;
                if (|grant) begin
                    id_d      = gnt_id;
                    alu_a_d   = req_a[8*int'(gnt_id) +: 8];
                    alu_b_d   = req_b[8*int'(gnt_id) +: 8];
                    alu_op_d  = req_op[4*int'(gnt_id) +: 4];
                    lat_cnt_d = LAT_INIT;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (lat_cnt_q == 3'd0) begin
                    res_d   = alu_result;
                    carry_d = alu_carry_out;
                    err_d   = is_err(alu_op_q, alu_b_q);
                    state_d = S_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if (resp_ready[id_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
                    if (op_count_q != 16'hFFFF) begin
                        op_count_d = op_count_q + 16'd1;
                    end
                    if (err_q && (err_count_q != 16'hFFFF)) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            lat_cnt_q   <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            op_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            lat_cnt_q   <= lat_cnt_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            op_count_q  <= op_count_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == S_RESP) begin
            resp_valid[id_q] = 1'b1;
        end
    end

    assign resp_result = res_q;
    assign resp_carry  = carry_q;
    assign resp_err    = err_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op_code = alu_op_q;
    assign busy        = (state_q != S_IDLE);
    assign op_count    = op_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: ALU model, transaction-level scheduler model checked every
// cycle, and directed scenarios with literal expectations.
module tb_alu_req_scheduler;
    import alu_sched_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT0: default build (N_REQ=4, ALU_LAT=1)
    logic [3:0]  req_valid0 = '0, req_ready0, resp_valid0, resp_ready0 = '0;
    logic [31:0] req_a0 = '0, req_b0 = '0;
    logic [15:0] req_op0 = '0;
    logic [7:0]  resp_result0, alu_a0, alu_b0, alu_res0;
    logic        resp_carry0, resp_err0, alu_c0, busy0;
    logic [3:0]  alu_op0;
    logic [15:0] op_count0, err_count0;

    // DUT1: ALU_LAT=3 build
    logic [3:0]  req_valid1 = '0, req_ready1, resp_valid1, resp_ready1 = 4'hF;
    logic [31:0] req_a1 = '0, req_b1 = '0;
    logic [15:0] req_op1 = '0;
    logic [7:0]  resp_result1, alu_a1, alu_b1, alu_res1;
    logic        resp_carry1, resp_err1, alu_c1, busy1;
    logic [3:0]  alu_op1;
    logic [15:0] op_count1, err_count1;

    alu_req_scheduler #(.N_REQ(4), .ALU_LAT(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_a(req_a0), .req_b(req_b0), .req_op(req_op0), .resp_valid(resp_valid0),
        .resp_ready(resp_ready0), .resp_result(resp_result0), .resp_carry(resp_carry0),
        .resp_err(resp_err0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_op_code(alu_op0),
        .alu_result(alu_res0), .alu_carry_out(alu_c0), .busy(busy0),
        .op_count(op_count0), .err_count(err_count0)
    );

    alu_req_scheduler #(.N_REQ(4), .ALU_LAT(3)) dut1 (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1), .req_op(req_op1), .resp_valid(resp_valid1),
        .resp_ready(resp_ready1), .resp_result(resp_result1), .resp_carry(resp_carry1),
        .resp_err(resp_err1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_op_code(alu_op1),
        .alu_result(alu_res1), .alu_carry_out(alu_c1), .busy(busy1),
        .op_count(op_count1), .err_count(err_count1)
    );

    // Combinational ALU: {carry, result}
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_MUL:  return {|p[15:8], p[7:0]};
            OP_DIV:  return (b == 8'd0) ? {1'b0, ALU_ERR_VAL} : {1'b0, a / b};
            default: return {1'b0, ALU_ERR_VAL};
        endcase
    endfunction

    assign {alu_c0, alu_res0} = alu_f(alu_a0, alu_b0, alu_op0);
    assign {alu_c1, alu_res1} = alu_f(alu_a1, alu_b1, alu_op1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scheduler model (DUT0) ----------------
    // Phase: 0 = free, 1 = operation in flight, 2 = result offered to owner.
    int          m_phase = 0, m_ptr = 0, m_id = 0, m_wait = 0;
    logic [7:0]  m_a = '0, m_b = '0, m_r = '0;
    logic [3:0]  m_op = '0;
    logic        m_c = 1'b0, m_err = 1'b0;
    logic [15:0] m_ops = '0, m_errs = '0;
    logic        sat_load = 1'b0;
    int          m_pick;

    function automatic int rr_pick(input logic [3:0] v, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (v[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    assign m_pick = rr_pick(req_valid0, m_ptr);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_ptr   <= 0;
            m_wait  <= 0;
            m_ops   <= '0;
            m_errs  <= '0;
        end else begin
            if (sat_load) m_ops <= 16'hFFFE;
            case (m_phase)
                0: if (m_pick >= 0) begin
                    m_id    <= m_pick;
                    m_a     <= req_a0[8*m_pick +: 8];
                    m_b     <= req_b0[8*m_pick +: 8];
                    m_op    <= req_op0[4*m_pick +: 4];
                    {m_c, m_r} <= alu_f(req_a0[8*m_pick +: 8], req_b0[8*m_pick +: 8],
                                        req_op0[4*m_pick +: 4]);
                    m_err   <= (req_op0[4*m_pick +: 4] > 4'd3) ||
                               ((req_op0[4*m_pick +: 4] == 4'd3) &&
                                (req_b0[8*m_pick +: 8] == 8'd0));
                    m_wait  <= 1;
                    m_phase <= 1;
                end
                1: begin
                    if (m_wait == 1) m_phase <= 2;
                    m_wait <= m_wait - 1;
                end
                default: if (resp_ready0[m_id]) begin
                    if (m_ops != 16'hFFFF) m_ops <= m_ops + 16'd1;
                    if (m_err && m_errs != 16'hFFFF) m_errs <= m_errs + 16'd1;
                    m_ptr   <= (m_id + 1) % 4;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            chk("req_ready", 32'(req_ready0),
                (m_phase == 0 && m_pick >= 0) ? (32'd1 << m_pick) : 32'd0);
            chk("resp_valid", 32'(resp_valid0), (m_phase == 2) ? (32'd1 << m_id) : 32'd0);
            chk("busy", 32'(busy0), 32'(m_phase != 0));
            if (m_phase != 0) begin
                chk("alu_a", 32'(alu_a0), 32'(m_a));
                chk("alu_b", 32'(alu_b0), 32'(m_b));
                chk("alu_op", 32'(alu_op0), 32'(m_op));
            end
            if (m_phase == 2) begin
                chk("resp_result", 32'(resp_result0), 32'(m_r));
                chk("resp_carry", 32'(resp_carry0), 32'(m_c));
                chk("resp_err", 32'(resp_err0), 32'(m_err));
            end
            if (!sat_load) begin
                chk("op_count", 32'(op_count0), 32'(m_ops));
                chk("err_count", 32'(err_count0), 32'(m_errs));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
        bit ok;
        ok = 1'b0;
        req_a0[8*id +: 8]  = a;
        req_b0[8*id +: 8]  = b;
        req_op0[4*id +: 4] = op;
        req_valid0[id]     = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (req_ready0[id]) ok = 1'b1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        if (!ok) chk("ready_timeout", 32'(req_ready0[id]), 32'd1);
        @(posedge clock);
        #1;
        req_valid0[id] = 1'b0;
    endtask

    task automatic wait_resp(input int id, output int cyc);
        cyc = 0;
        while (!resp_valid0[id] && cyc < 30) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        if (cyc >= 30) chk("resp_timeout", 32'(resp_valid0[id]), 32'd1);
    endtask

    task automatic finish_resp(input int id, input int hold);
        repeat (hold) begin
            @(posedge clock);
            #1;
        end
        resp_ready0[id] = 1'b1;
        @(posedge clock);
        #1;
        resp_ready0[id] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    int cyc, gid;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        #3;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid0), 32'd0);
        chk("rst_alu_a", 32'(alu_a0), 32'd0);
        chk("rst_op_count", 32'(op_count0), 32'd0);
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // 1: single ADD on requester 0
        issue(0, 8'd200, 8'd100, OP_ADD);
        chk("t1_exec_no_resp", 32'(resp_valid0[0]), 32'd0);
        wait_resp(0, cyc);
        chk("t1_latency", cyc, 32'd1);
        chk("t1_result", 32'(resp_result0), 32'd44);
        chk("t1_carry", 32'(resp_carry0), 32'd1);
        chk("t1_err", 32'(resp_err0), 32'd0);
        finish_resp(0, 0);

        // 3: divide by zero and undefined opcode
        issue(2, 8'd9, 8'd0, OP_DIV);
        wait_resp(2, cyc);
        chk("t3_div0_result", 32'(resp_result0), 32'hAC);
        chk("t3_div0_err", 32'(resp_err0), 32'd1);
        finish_resp(2, 1);
        chk("t3_err_count1", 32'(err_count0), 32'd1);
        issue(1, 8'd3, 8'd4, 4'h7);
        wait_resp(1, cyc);
        chk("t3_op7_result", 32'(resp_result0), 32'hAC);
        chk("t3_op7_err", 32'(resp_err0), 32'd1);
        finish_resp(1, 0);
        chk("t3_err_count2", 32'(err_count0), 32'd2);

        // 2: all four requesting from pointer 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a0[8*i +: 8]  = 8'(10 * i + 1);
            req_b0[8*i +: 8]  = 8'(i + 2);
            req_op0[4*i +: 4] = 4'(i);
        end
        req_valid0 = 4'hF;
        for (int k = 0; k < 5; k++) begin
            gid = -1;
            for (int w = 0; w < 20 && gid < 0; w++) begin
                #1;
                for (int i = 0; i < 4; i++) if (req_ready0[i]) gid = i;
                if (gid < 0) begin
                    @(posedge clock);
                    #1;
                end
            end
            chk("t2_grant_order", gid, exp_order[k]);
            if (gid < 0) gid = 0;
            @(posedge clock);
            #1;
            if (k == 4) req_valid0 = '0;
            wait_resp(gid, cyc);
            finish_resp(gid, 1);
        end
        chk("t2_op_count", 32'(op_count0), 32'd5);

        // 4: MUL with a stalled consumer; a competing request must wait
        issue(3, 8'd16, 8'd17, OP_MUL);
        wait_resp(3, cyc);
        req_valid0[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t4_no_ready", 32'(req_ready0), 32'd0);
            chk("t4_result", 32'(resp_result0), 32'h10);
            chk("t4_carry", 32'(resp_carry0), 32'd1);
            chk("t4_resp_valid", 32'(resp_valid0), 32'b1000);
            @(posedge clock);
            #1;
        end
        req_valid0[0] = 1'b0;
        finish_resp(3, 0);
        chk("t4_idle", 32'(busy0), 32'd0);

        // 5: asynchronous reset while executing
        issue(1, 8'd1, 8'd2, OP_ADD);
        chk("t5_in_exec", 32'(busy0), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy0), 32'd0);
        chk("t5_resp_valid", 32'(resp_valid0), 32'd0);
        chk("t5_alu_a", 32'(alu_a0), 32'd0);
        chk("t5_alu_b", 32'(alu_b0), 32'd0);
        chk("t5_alu_op", 32'(alu_op0), 32'd0);
        chk("t5_result", 32'(resp_result0), 32'd0);
        chk("t5_op_count", 32'(op_count0), 32'd0);
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("t5_no_resp", 32'(resp_valid0), 32'd0);
        req_valid0 = 4'b1010;
        #1;
        chk("t5_ptr_zero", 32'(req_ready0), 32'b0010);
        #1;
        req_valid0 = '0;

        // 6a: saturation of op_count
        @(posedge clock);
        #1;
        force dut0.op_count_q = 16'hFFFE;
        sat_load = 1'b1;
        @(posedge clock);
        #1;
        release dut0.op_count_q;
        sat_load = 1'b0;
        issue(0, 8'd1, 8'd1, OP_ADD);
        wait_resp(0, cyc);
        finish_resp(0, 0);
        chk("t6_sat_ffff", 32'(op_count0), 32'hFFFF);
        issue(0, 8'd2, 8'd2, OP_ADD);
        wait_resp(0, cyc);
        finish_resp(0, 0);
        chk("t6_sat_hold", 32'(op_count0), 32'hFFFF);

        // 6b: ALU_LAT=3 build, SUB 5-7
        req_a1[7:0]  = 8'd5;
        req_b1[7:0]  = 8'd7;
        req_op1[3:0] = OP_SUB;
        req_valid1   = 4'b0001;
        #1;
        chk("t6_lat3_ready", 32'(req_ready1), 32'b0001);
        @(posedge clock);
        #1;
        req_valid1 = '0;
        cyc = 0;
        while (!resp_valid1[0] && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("t6_lat3_latency", cyc, 32'd3);
        chk("t6_lat3_result", 32'(resp_result1), 32'hFE);
        chk("t6_lat3_carry", 32'(resp_carry1), 32'd1);
        chk("t6_lat3_err", 32'(resp_err1), 32'd0);
        @(posedge clock);
        #1;
        chk("t6_lat3_count", 32'(op_count1), 32'd1);

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
